cache_set_assoc_engine: RTL and testbench
=========================================

Name: cache_set_assoc_engine

Overview:
- Parametrised set-associative cache tag/state engine for trace-driven cache modelling.
- Accepts one address request at a time over a valid/ready handshake and looks it up in NUMSETS x ASSOC tag storage.
- Applies the selected replacement and write policy, reports hit, victim and writeback per request, and keeps saturating statistics counters.
- Successor to the single-set prototype: real set indexing, per-way valid/dirty state, and selectable LRU/FIFO replacement and WBWA/WTNA write policy.

Parameters:
- ADDR_W, 32: request address width.
- BLOCKSIZE, 64: bytes per block; power of two.
- CACHESIZE, 32768: total bytes; power of two.
- ASSOC, 8: ways per set; power of two, >=1.
- CNT_W, 16: statistics counter width.
- NUMSETS (localparam) = CACHESIZE/(BLOCKSIZE*ASSOC); must be >=1.
- TAG_W (localparam) = ADDR_W - log2(BLOCKSIZE) - log2(NUMSETS).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  engine idle and able to accept.
- req_addr  in  ADDR_W  byte address.
- req_write  in  1  1=write, 0=read.
- write_policy  in  1  0=write-back/write-allocate (WBWA), 1=write-through/no-allocate (WTNA).
- replace_policy  in  1  0=LRU, 1=FIFO.
- resp_valid  out  1  one-cycle response strobe.
- resp_hit  out  1  lookup hit.
- resp_evict  out  1  a valid line was replaced.
- resp_evict_tag  out  TAG_W  tag of the replaced line.
- resp_evict_dirty  out  1  replaced line was dirty (writeback).
- num_reads, num_writes, num_read_misses, num_write_misses, num_writebacks  out  CNT_W each  statistics.

Behaviour:
- Address split: offset = addr[log2(BLOCKSIZE)-1:0]; index = next log2(NUMSETS) bits; tag = remaining upper bits.
- Per way state: valid, dirty, tag, age[log2(ASSOC)-1:0].
- Reset (asserted low, asynchronous):
  - all valid/dirty/age = 0, all counters = 0;
  - resp_* = 0, state = IDLE, req_ready = 1.
  - Reset asserted mid-operation aborts the request: no resp_valid, no counter update.
- FSM: IDLE -> LOOKUP -> UPDATE -> RESP -> IDLE.
  - IDLE: req_ready = 1. On req_valid & req_ready, capture addr, write, and both policy inputs; go to LOOKUP. Policy inputs are not sampled at any other time.
  - LOOKUP: compare tag against all valid ways of the set; record hit way. On miss, select the victim:
    - lowest-index invalid way, if any;
    - otherwise the way with age == ASSOC-1.
  - UPDATE:
    - Read hit: LRU promotes the way; FIFO makes no change.
    - Write hit: WBWA sets dirty; WTNA leaves dirty unchanged. LRU promotes; FIFO makes no change.
    - Read miss, or write miss under WBWA: fill the victim (valid=1, tag, dirty = req_write). If the victim was valid, set resp_evict and the evict tag; if it was also dirty, increment num_writebacks.
    - Write miss under WTNA: no allocation, no state change.
    - Promote/fill age rule: the touched way's age becomes 0; every valid way whose age is less than the touched way's old age increments. On a fill, the old age is taken as ASSOC-1.
  - RESP: resp_valid = 1 for exactly one cycle; resp_* hold the result. resp_* clear to 0 in the next cycle. Return to IDLE.
- Latency: accept at cycle N; resp_valid at N+3; next accept possible at N+4. req_ready = 0 in LOOKUP, UPDATE and RESP.
- Counters: num_reads or num_writes always increments; the matching miss counter increments on a miss. All counters are updated in UPDATE and saturate at all-ones, no wrap.
- Miss rate is not computed in hardware; it is derived from the counters.

Optional Feature:
- Macro CACHE_FLUSH_EN.
- Defined:
  - Adds input flush (1 bit), sampled only in IDLE; flush takes priority over req_valid.
  - Enters state FLUSH, which walks set 0..NUMSETS-1, one set per cycle. Each visited set has all ways invalidated and ages cleared, and num_writebacks increases by the number of valid dirty ways in that set (saturating).
  - req_ready = 0 throughout; returns to IDLE after the last set; no resp_valid is issued.
- Undefined: no flush port and no FLUSH state; behaviour is otherwise identical.

Test Plan:
- Test configuration unless noted: BLOCKSIZE=16, CACHESIZE=256, ASSOC=2 (NUMSETS=8, tag = addr>>7).
- Reset: hold reset=0 for 3 cycles, release -> all counters 0, resp_valid=0, req_ready=1.
- LRU basic: read 0x100 then read 0x104 -> resp_hit 0 then 1, each resp_valid exactly 3 cycles after accept, num_reads=2, num_read_misses=1.
- LRU vs FIFO: reads 0x000, 0x080, 0x000, 0x100, 0x000.
  - LRU: 4th read evicts tag 1; final read hits; read_misses=3.
  - FIFO: 4th read evicts tag 0; final read misses; read_misses=4.
- Write policy:
  - WBWA, LRU: write 0x000, read 0x080, read 0x100 -> 3rd response has resp_evict=1, resp_evict_tag=0, resp_evict_dirty=1; num_writebacks=1.
  - WTNA: write 0x000, then read 0x000 -> both miss; num_write_misses=1; num_writebacks=0.
- Reset mid-op: accept read 0x000, assert reset during LOOKUP -> no resp_valid, counters 0. After release, read 0x000 -> miss.
- Saturation: CNT_W=4, 20 reads of 0x000 -> num_reads=15, num_read_misses=1. With CACHE_FLUSH_EN, a flush after a dirty write adds 1 to num_writebacks, and the next read 0x000 misses.

Source files
------------

// File: rtl/cache_set_assoc_engine.sv
`default_nettype none
// ============================================================================
// Module   : cache_set_assoc_engine
// Brief    : Set-associative tag/state engine with LRU/FIFO replacement,
//            WBWA/WTNA write policy and saturating statistics counters.
//            Optional set-walk flush enabled by macro CACHE_FLUSH_EN.
// Revision : 1.0 - initial release
// ============================================================================
module cache_set_assoc_engine #(
    parameter int ADDR_W    = 32,
    parameter int BLOCKSIZE = 64,
    parameter int CACHESIZE = 32768,
    parameter int ASSOC     = 8,
    parameter int CNT_W     = 16,
    localparam int NUMSETS  = CACHESIZE / (BLOCKSIZE * ASSOC),
    localparam int TAG_W    = ADDR_W - $clog2(BLOCKSIZE) - $clog2(NUMSETS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              req_write,
    input  logic              write_policy,
    input  logic              replace_policy,
`ifdef CACHE_FLUSH_EN
    input  logic              flush,
`endif
    output logic              resp_valid,
    output logic              resp_hit,
    output logic              resp_evict,
    output logic [TAG_W-1:0]  resp_evict_tag,
    output logic              resp_evict_dirty,
    output logic [CNT_W-1:0]  num_reads,
    output logic [CNT_W-1:0]  num_writes,
    output logic [CNT_W-1:0]  num_read_misses,
    output logic [CNT_W-1:0]  num_write_misses,
    output logic [CNT_W-1:0]  num_writebacks
);

    localparam int c_OFF_W    = $clog2(BLOCKSIZE);
    localparam int c_IDX_BITS = $clog2(NUMSETS);
    localparam int c_IDX_W    = (c_IDX_BITS > 0) ? c_IDX_BITS : 1;
    localparam int c_WAY_W    = (ASSOC > 1) ? $clog2(ASSOC) : 1;
    localparam int c_BLK_W    = ADDR_W - c_OFF_W;
    localparam int c_SUM_W    = CNT_W + c_WAY_W + 1;
    localparam logic [c_WAY_W-1:0] c_AGE_MAX  = c_WAY_W'(ASSOC - 1);

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_LOOKUP = 3'd1;
    localparam logic [2:0] c_UPDATE = 3'd2;
    localparam logic [2:0] c_RESP   = 3'd3;
`ifdef CACHE_FLUSH_EN
    localparam logic [2:0] c_FLUSH  = 3'd4;
    localparam logic [c_IDX_W-1:0] c_LAST_SET = c_IDX_W'(NUMSETS - 1);
`endif

    logic [2:0]         r_state;
    logic [c_BLK_W-1:0] r_blk;
    logic               r_write;
    logic               r_wp;
    logic               r_rp;

    logic [ASSOC-1:0]   r_valid [NUMSETS];
    logic [ASSOC-1:0]   r_dirty [NUMSETS];
    logic [TAG_W-1:0]   r_tag   [NUMSETS][ASSOC];
    logic [c_WAY_W-1:0] r_age   [NUMSETS][ASSOC];

    logic               r_hit;
    logic [c_WAY_W-1:0] r_way;
    logic               r_vict_valid;
    logic               r_vict_dirty;
    logic [TAG_W-1:0]   r_vict_tag;

    logic               r_resp_valid;
    logic               r_resp_hit;
    logic               r_resp_evict;
    logic [TAG_W-1:0]   r_resp_evict_tag;
    logic               r_resp_evict_dirty;
    logic [CNT_W-1:0]   r_num_reads;
    logic [CNT_W-1:0]   r_num_writes;
    logic [CNT_W-1:0]   r_num_read_misses;
    logic [CNT_W-1:0]   r_num_write_misses;
    logic [CNT_W-1:0]   r_num_writebacks;

    logic [c_IDX_W-1:0] w_idx;
    logic [TAG_W-1:0]   w_tag;
    logic               w_hit;
    logic [c_WAY_W-1:0] w_hit_way;
    logic               w_inv_found;
    logic [c_WAY_W-1:0] w_inv_way;
    logic [c_WAY_W-1:0] w_old_way;
    logic [c_WAY_W-1:0] w_victim;
    logic               w_fill;
    logic               w_touch;
    logic [c_WAY_W-1:0] w_old_age;
    logic               w_accept;

    // Offset bits never influence the lookup; only block address is stored.
    generate
        if (c_OFF_W > 0) begin : g_off
            logic w_unused_offset;
            assign w_unused_offset = &{1'b0, req_addr[c_OFF_W-1:0]};
        end
        if (c_IDX_BITS > 0) begin : g_idx
            assign w_idx = r_blk[c_IDX_BITS-1:0];
        end else begin : g_idx_none
            assign w_idx = '0;
        end
    endgenerate

    assign w_tag = r_blk[c_BLK_W-1 -: TAG_W];

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [c_SUM_W-1:0] b);
        logic [c_SUM_W-1:0] s;
        s = c_SUM_W'(a) + b;
        if (s[c_SUM_W-1:CNT_W] != '0) return '1;
        return s[CNT_W-1:0];
    endfunction

    always_comb begin
        w_hit       = 1'b0;
        w_hit_way   = '0;
        w_inv_found = 1'b0;
        w_inv_way   = '0;
        w_old_way   = '0;
        for (int i = 0; i < ASSOC; i++) begin
            if (!w_hit && r_valid[w_idx][i] && (r_tag[w_idx][i] == w_tag)) begin
                w_hit     = 1'b1;
                w_hit_way = c_WAY_W'(i);
            end
            if (r_age[w_idx][i] == c_AGE_MAX) w_old_way = c_WAY_W'(i);
        end
        // Descending scan leaves the lowest-index invalid way selected.
        for (int i = ASSOC - 1; i >= 0; i--) begin
            if (!r_valid[w_idx][i]) begin
                w_inv_found = 1'b1;
                w_inv_way   = c_WAY_W'(i);
            end
        end
        w_victim = w_inv_found ? w_inv_way : w_old_way;
    end

    assign w_fill    = !r_hit && (!r_write || !r_wp);
    assign w_touch   = r_hit ? !r_rp : w_fill;
    assign w_old_age = r_hit ? r_age[w_idx][r_way] : c_AGE_MAX;

`ifdef CACHE_FLUSH_EN
    logic [c_IDX_W-1:0] r_flush_set;
    logic [c_SUM_W-1:0] w_flush_wb;
    always_comb begin
        w_flush_wb = '0;
        for (int i = 0; i < ASSOC; i++) begin
            w_flush_wb = w_flush_wb +
                c_SUM_W'(r_valid[r_flush_set][i] & r_dirty[r_flush_set][i]);
        end
    end
    assign req_ready = (r_state == c_IDLE) && !flush;
`else
    assign req_ready = (r_state == c_IDLE);
`endif

    assign w_accept = req_valid && req_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state            <= c_IDLE;
            r_blk              <= '0;
            r_write            <= 1'b0;
            r_wp               <= 1'b0;
            r_rp               <= 1'b0;
            r_hit              <= 1'b0;
            r_way              <= '0;
            r_vict_valid       <= 1'b0;
            r_vict_dirty       <= 1'b0;
            r_vict_tag         <= '0;
            r_resp_valid       <= 1'b0;
            r_resp_hit         <= 1'b0;
            r_resp_evict       <= 1'b0;
            r_resp_evict_tag   <= '0;
            r_resp_evict_dirty <= 1'b0;
            r_num_reads        <= '0;
            r_num_writes       <= '0;
            r_num_read_misses  <= '0;
            r_num_write_misses <= '0;
            r_num_writebacks   <= '0;
`ifdef CACHE_FLUSH_EN
            r_flush_set        <= '0;
`endif
            for (int s = 0; s < NUMSETS; s++) begin
                r_valid[s] <= '0;
                r_dirty[s] <= '0;
                for (int i = 0; i < ASSOC; i++) begin
                    r_tag[s][i] <= '0;
                    r_age[s][i] <= '0;
                end
            end
        end else begin
            case (r_state)
                c_IDLE: begin
`ifdef CACHE_FLUSH_EN
                    if (flush) begin
                        r_flush_set <= '0;
                        r_state     <= c_FLUSH;
                    end else
`endif
                    if (w_accept) begin
                        r_blk   <= req_addr[ADDR_W-1:c_OFF_W];
                        r_write <= req_write;
                        r_wp    <= write_policy;
                        r_rp    <= replace_policy;
                        r_state <= c_LOOKUP;
                    end
                end
                c_LOOKUP: begin
                    r_hit        <= w_hit;
                    r_way        <= w_hit ? w_hit_way : w_victim;
                    r_vict_valid <= r_valid[w_idx][w_victim];
                    r_vict_dirty <= r_dirty[w_idx][w_victim];
                    r_vict_tag   <= r_tag[w_idx][w_victim];
                    r_state      <= c_UPDATE;
                end
                c_UPDATE: begin
                    if (w_touch) begin
                        for (int i = 0; i < ASSOC; i++) begin
                            if (c_WAY_W'(i) == r_way)
                                r_age[w_idx][i] <= '0;
                            else if (r_valid[w_idx][i] && (r_age[w_idx][i] < w_old_age))
                                r_age[w_idx][i] <= r_age[w_idx][i] + 1'b1;
                        end
                    end
                    if (r_hit && r_write && !r_wp) r_dirty[w_idx][r_way] <= 1'b1;
                    if (w_fill) begin
                        r_valid[w_idx][r_way] <= 1'b1;
                        r_dirty[w_idx][r_way] <= r_write;
                        r_tag[w_idx][r_way]   <= w_tag;
                    end
                    if (r_write) begin
                        r_num_writes <= sat_add(r_num_writes, c_SUM_W'(1));
                        if (!r_hit) r_num_write_misses <= sat_add(r_num_write_misses, c_SUM_W'(1));
                    end else begin
                        r_num_reads <= sat_add(r_num_reads, c_SUM_W'(1));
                        if (!r_hit) r_num_read_misses <= sat_add(r_num_read_misses, c_SUM_W'(1));
                    end
                    if (w_fill && r_vict_valid && r_vict_dirty)
                        r_num_writebacks <= sat_add(r_num_writebacks, c_SUM_W'(1));
                    r_resp_valid       <= 1'b1;
                    r_resp_hit         <= r_hit;
                    r_resp_evict       <= w_fill && r_vict_valid;
                    r_resp_evict_tag   <= (w_fill && r_vict_valid) ? r_vict_tag : '0;
                    r_resp_evict_dirty <= w_fill && r_vict_valid && r_vict_dirty;
                    r_state            <= c_RESP;
                end
                c_RESP: begin
                    r_resp_valid       <= 1'b0;
                    r_resp_hit         <= 1'b0;
                    r_resp_evict       <= 1'b0;
                    r_resp_evict_tag   <= '0;
                    r_resp_evict_dirty <= 1'b0;
                    r_state            <= c_IDLE;
                end
`ifdef CACHE_FLUSH_EN
                c_FLUSH: begin
                    r_valid[r_flush_set] <= '0;
                    r_dirty[r_flush_set] <= '0;
                    for (int i = 0; i < ASSOC; i++) r_age[r_flush_set][i] <= '0;
                    r_num_writebacks <= sat_add(r_num_writebacks, w_flush_wb);
                    if (r_flush_set == c_LAST_SET) r_state <= c_IDLE;
                    else r_flush_set <= r_flush_set + 1'b1;
                end
`endif
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign resp_valid       = r_resp_valid;
    assign resp_hit         = r_resp_hit;
    assign resp_evict       = r_resp_evict;
    assign resp_evict_tag   = r_resp_evict_tag;
    assign resp_evict_dirty = r_resp_evict_dirty;
    assign num_reads        = r_num_reads;
    assign num_writes       = r_num_writes;
    assign num_read_misses  = r_num_read_misses;
    assign num_write_misses = r_num_write_misses;
    assign num_writebacks   = r_num_writebacks;

endmodule
`default_nettype wire

// File: tb/tb_cache_set_assoc_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_cache_set_assoc_engine
// Brief    : Scoreboard bench for cache_set_assoc_engine (16B blocks, 256B,
//            2-way, 4-bit counters); flush scenario under CACHE_FLUSH_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cache_set_assoc_engine;

    localparam int c_TAG_W = 25;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic               req_valid = 1'b0;
    logic               req_ready;
    logic [31:0]        req_addr = '0;
    logic               req_write = 1'b0;
    logic               write_policy = 1'b0;
    logic               replace_policy = 1'b0;
    logic               flush = 1'b0;
    logic               resp_valid;
    logic               resp_hit;
    logic               resp_evict;
    logic [c_TAG_W-1:0] resp_evict_tag;
    logic               resp_evict_dirty;
    logic [3:0]         num_reads, num_writes, num_read_misses, num_write_misses, num_writebacks;

    cache_set_assoc_engine #(
        .ADDR_W(32), .BLOCKSIZE(16), .CACHESIZE(256), .ASSOC(2), .CNT_W(4)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_write(req_write), .write_policy(write_policy), .replace_policy(replace_policy),
`ifdef CACHE_FLUSH_EN
        .flush(flush),
`endif
        .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_evict(resp_evict),
        .resp_evict_tag(resp_evict_tag), .resp_evict_dirty(resp_evict_dirty),
        .num_reads(num_reads), .num_writes(num_writes),
        .num_read_misses(num_read_misses), .num_write_misses(num_write_misses),
        .num_writebacks(num_writebacks)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic               hit;
        logic               ev;
        logic [c_TAG_W-1:0] tag;
        logic               dirty;
        int                 cyc;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    logic r_prev_valid = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Response monitor: pops the scoreboard on every strobe.
    always @(negedge clk) begin
        exp_t e;
        if (reset && resp_valid) begin
            if (q.size() == 0) begin
                chk("unexpected_resp", 32'd1, 32'd0);
            end else begin
                e = q.pop_front();
                chk("resp_hit", 32'(resp_hit), 32'(e.hit));
                chk("resp_evict", 32'(resp_evict), 32'(e.ev));
                chk("resp_evict_tag", 32'(resp_evict_tag), 32'(e.tag));
                chk("resp_evict_dirty", 32'(resp_evict_dirty), 32'(e.dirty));
                chk("resp_latency", 32'(cyc), 32'(e.cyc));
            end
        end else if (reset && r_prev_valid) begin
            chk("resp_clear", 32'({resp_hit, resp_evict, resp_evict_dirty, resp_evict_tag != '0}), 32'd0);
        end
        r_prev_valid = resp_valid;
    end

    task automatic issue(input logic [31:0] a, input logic wr, input logic wp, input logic rp,
                         input logic eh, input logic ee, input logic [c_TAG_W-1:0] et,
                         input logic ed);
        exp_t e;
        int n = 0;
        @(negedge clk);
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            chk("ready_timeout", 32'd0, 32'd1);
            return;
        end
        req_valid = 1'b1; req_addr = a; req_write = wr;
        write_policy = wp; replace_policy = rp;
        e.hit = eh; e.ev = ee; e.tag = et; e.dirty = ed; e.cyc = cyc + 3;
        q.push_back(e);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) begin
            chk("resp_timeout", 32'(q.size()), 32'd0);
            q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        q.delete();
    endtask

    task automatic chk_cnt(input logic [3:0] r, input logic [3:0] w, input logic [3:0] rm,
                           input logic [3:0] wm, input logic [3:0] wb);
        chk("num_reads", 32'(num_reads), 32'(r));
        chk("num_writes", 32'(num_writes), 32'(w));
        chk("num_read_misses", 32'(num_read_misses), 32'(rm));
        chk("num_write_misses", 32'(num_write_misses), 32'(wm));
        chk("num_writebacks", 32'(num_writebacks), 32'(wb));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        do_reset();
        chk("reset_resp_valid", 32'(resp_valid), 32'd0);
        chk("reset_req_ready", 32'(req_ready), 32'd1);
        chk_cnt(0, 0, 0, 0, 0);

        // LRU basic: miss then same-block hit
        issue(32'h100, 0, 0, 0, 0, 0, 0, 0);
        issue(32'h104, 0, 0, 0, 1, 0, 0, 0);
        drain();
        chk_cnt(2, 0, 1, 0, 0);

        // LRU replacement
        do_reset();
        issue(32'h000, 0, 0, 0, 0, 0, 0, 0);
        issue(32'h080, 0, 0, 0, 0, 0, 0, 0);
        issue(32'h000, 0, 0, 0, 1, 0, 0, 0);
        issue(32'h100, 0, 0, 0, 0, 1, 25'd1, 0);
        issue(32'h000, 0, 0, 0, 1, 0, 0, 0);
        drain();
        chk_cnt(5, 0, 3, 0, 0);

        // FIFO replacement
        do_reset();
        issue(32'h000, 0, 0, 1, 0, 0, 0, 0);
        issue(32'h080, 0, 0, 1, 0, 0, 0, 0);
        issue(32'h000, 0, 0, 1, 1, 0, 0, 0);
        issue(32'h100, 0, 0, 1, 0, 1, 25'd0, 0);
        issue(32'h000, 0, 0, 1, 0, 1, 25'd1, 0);
        drain();
        chk_cnt(5, 0, 4, 0, 0);

        // WBWA write miss allocates dirty, later written back
        do_reset();
        issue(32'h000, 1, 0, 0, 0, 0, 0, 0);
        issue(32'h080, 0, 0, 0, 0, 0, 0, 0);
        issue(32'h100, 0, 0, 0, 0, 1, 25'd0, 1);
        drain();
        chk_cnt(2, 1, 2, 1, 1);

        // WTNA write miss does not allocate
        do_reset();
        issue(32'h000, 1, 1, 0, 0, 0, 0, 0);
        issue(32'h000, 0, 1, 0, 0, 0, 0, 0);
        drain();
        chk_cnt(1, 1, 1, 1, 0);

        // Write hit: WBWA dirties the line, WTNA leaves it clean
        do_reset();
        issue(32'h000, 0, 0, 0, 0, 0, 0, 0);
        issue(32'h008, 1, 0, 0, 1, 0, 0, 0);
        issue(32'h080, 0, 0, 0, 0, 0, 0, 0);
        issue(32'h100, 0, 0, 0, 0, 1, 25'd0, 1);
        drain();
        chk_cnt(3, 1, 3, 0, 1);
        do_reset();
        issue(32'h000, 0, 1, 0, 0, 0, 0, 0);
        issue(32'h008, 1, 1, 0, 1, 0, 0, 0);
        issue(32'h080, 0, 1, 0, 0, 0, 0, 0);
        issue(32'h100, 0, 1, 0, 0, 1, 25'd0, 0);
        drain();
        chk_cnt(3, 1, 3, 0, 0);

        // Reset during LOOKUP aborts the request
        do_reset();
        @(negedge clk);
        req_valid = 1'b1; req_addr = 32'h000; req_write = 1'b0;
        write_policy = 1'b0; replace_policy = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        chk("busy_in_lookup", 32'(req_ready), 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (5) @(negedge clk);
        chk_cnt(0, 0, 0, 0, 0);
        issue(32'h000, 0, 0, 0, 0, 0, 0, 0);
        drain();
        chk_cnt(1, 0, 1, 0, 0);

        // Counter saturation
        do_reset();
        for (int i = 0; i < 20; i++) issue(32'h000, 0, 0, 0, (i != 0), 0, 0, 0);
        drain();
        chk_cnt(15, 0, 1, 0, 0);

`ifdef CACHE_FLUSH_EN
        // Flush writes back the dirty line and invalidates it
        do_reset();
        issue(32'h000, 1, 0, 0, 0, 0, 0, 0);
        drain();
        chk("wb_before_flush", 32'(num_writebacks), 32'd0);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("busy_in_flush", 32'(req_ready), 32'd0);
        begin
            int n = 0;
            while (!req_ready && n < 30) begin
                @(negedge clk);
                n++;
            end
            chk("flush_done", 32'(req_ready), 32'd1);
        end
        chk("wb_after_flush", 32'(num_writebacks), 32'd1);
        issue(32'h000, 0, 0, 0, 0, 0, 0, 0);
        drain();
        chk_cnt(1, 1, 1, 1, 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
